gate_table_checker: RTL and testbench

Self-checking truth-table sequencer for the gate exercises. It drives every input combination into a combinational gate network under test, lets each vector settle, and captures the network's single output. At the end of the sweep it compares the captured table against an expected table and reports pass/fail plus the first mismatching vector. This is the clocked counterpart to the hand-written `$monitor` benches: the checker generates the stimulus and consumes the response.

---
 rtl/gate_table_checker.sv | 128 ++++++++++++
 tb/tb_gate_table_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_table_checker.sv
// Truth-table sweeper: drives every input vector into a gate network,
// samples its output after a settle window and compares to a reference.
module gate_table_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      stim,
    input  logic                 s,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN-1:0]      fail_index
);

    localparam int              W        = 2**N_IN;
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
    localparam logic [N_IN-1:0] LAST     = N_IN'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            r_state;
    logic [W-1:0]      r_exp;
    logic [W-1:0]      r_cap;
    logic [N_IN-1:0]   r_vec;
    logic [3:0]        r_cnt;
    logic [N_IN-1:0]   r_stim;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [N_IN-1:0]   r_fidx;

    logic [W-1:0]      w_cap_next;
    logic [W-1:0]      w_diff;
    logic [N_IN-1:0]   w_fidx;
    logic              w_sample;

    // Table as it will look once the current vector is sampled, so the
    // verdict on the final edge already includes the last bit.
    always_comb begin
        w_cap_next        = r_cap;
        w_cap_next[r_vec] = s;
    end

    assign w_diff   = r_exp ^ w_cap_next;
    assign w_sample = (r_cnt == SETTLE_C);

    always_comb begin
        w_fidx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (w_diff[i]) w_fidx = N_IN'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_exp   <= '0;
            r_cap   <= '0;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fidx  <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_exp   <= expected;
                        r_cap   <= '0;
                        r_pass  <= 1'b0;
                        r_fidx  <= '0;
                        r_vec   <= '0;
                        r_cnt   <= '0;
                        r_stim  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_cap <= w_cap_next;
                        r_cnt <= '0;
                        if (r_vec == LAST) begin
                            r_vec   <= '0;
                            r_stim  <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_diff == '0);
                            r_fidx  <= w_fidx;
                            r_state <= DONE;
                        end else begin
                            r_vec  <= r_vec + 1'b1;
                            r_stim <= r_vec + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stim       = r_stim;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign captured   = r_cap;
    assign fail_index = r_fidx;

endmodule

// File: tb/tb_gate_table_checker.sv
// Bench for gate_table_checker: table of sweeps on two builds
// (SETTLE=1 and SETTLE=0) plus reset, re-start and held-start sequences.
module tb_gate_table_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [3:0] expected0, expected1;
    logic [1:0] stim0, stim1;
    logic       s0, s1;
    logic       busy0, busy1;
    logic       done0, done1;
    logic       pass0, pass1;
    logic [3:0] cap0, cap1;
    logic [1:0] fi0, fi1;
    logic       mode0;
    int         n_pass = 0;
    int         n_tot  = 0;
    int         ndone0 = 0;

    always #5 clk = ~clk;

    // mode0=0: ~a|b, mode0=1: NOR(a,b); a = stim[1], b = stim[0]
    always_comb begin
        if (mode0) s0 = ~(stim0[1] | stim0[0]);
        else       s0 = ~stim0[1] | stim0[0];
    end
    assign s1 = ~(stim1[1] | stim1[0]);

    always @(negedge clk) if (done0) ndone0++;

    gate_table_checker #(.N_IN(2), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected(expected0),
        .stim(stim0), .s(s0), .busy(busy0), .done(done0), .pass(pass0),
        .captured(cap0), .fail_index(fi0)
    );

    gate_table_checker #(.N_IN(2), .SETTLE(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1),
        .stim(stim1), .s(s1), .busy(busy1), .done(done1), .pass(pass1),
        .captured(cap1), .fail_index(fi1)
    );

    typedef struct {
        bit         sel;
        bit         mode;
        logic [3:0] ev;
        logic       pass;
        logic [3:0] cap;
        logic [1:0] fi;
        int         dedge;
    } vec_t;

    vec_t tbl[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [1:0] st(bit sel);
        return sel ? stim1 : stim0;
    endfunction
    function automatic logic bsy(bit sel);
        return sel ? busy1 : busy0;
    endfunction
    function automatic logic dn(bit sel);
        return sel ? done1 : done0;
    endfunction
    function automatic logic ps(bit sel);
        return sel ? pass1 : pass0;
    endfunction
    function automatic logic [3:0] cp(bit sel);
        return sel ? cap1 : cap0;
    endfunction
    function automatic logic [1:0] fx(bit sel);
        return sel ? fi1 : fi0;
    endfunction

    // Accept at edge 0, then step until done shows (bounded).
    task automatic sweep(input bit sel, input logic [3:0] ev,
                         output int dedge, output bit stim_ok,
                         output bit clr_ok);
        int per;
        per = sel ? 1 : 2;
        if (sel) begin
            expected1 = ev;
            start1    = 1'b1;
        end else begin
            expected0 = ev;
            start0    = 1'b1;
        end
        step();
        start0  = 1'b0;
        start1  = 1'b0;
        clr_ok  = (cp(sel) == 4'd0) && !ps(sel) && (fx(sel) == 2'd0)
                  && bsy(sel);
        stim_ok = (st(sel) == 2'd0);
        dedge   = -1;
        for (int e = 1; e <= 40 && dedge < 0; e++) begin
            step();
            if (dn(sel)) dedge = e;
            else if (st(sel) != 2'(e / per) || !bsy(sel)) stim_ok = 1'b0;
        end
    endtask

    initial begin
        int  dedge;
        bit  sok, cok;
        int  nd;

        tbl[0] = '{0, 0, 4'b1011, 1'b1, 4'b1011, 2'd0, 8};
        tbl[1] = '{0, 0, 4'b1111, 1'b0, 4'b1011, 2'd2, 8};
        tbl[2] = '{1, 1, 4'b0001, 1'b1, 4'b0001, 2'd0, 4};
        tbl[3] = '{1, 1, 4'b1011, 1'b0, 4'b0001, 2'd1, 4};
        tbl[4] = '{0, 1, 4'b0001, 1'b1, 4'b0001, 2'd0, 8};
        tbl[5] = '{0, 0, 4'b0011, 1'b0, 4'b1011, 2'd3, 8};
        tbl[6] = '{0, 0, 4'b0000, 1'b0, 4'b1011, 2'd0, 8};

        rst_n     = 1'b0;
        start0    = 1'b0;
        start1    = 1'b0;
        expected0 = '0;
        expected1 = '0;
        mode0     = 1'b0;
        step();
        step();
        chk("reset_dut0", {stim0, busy0, done0, pass0, cap0, fi0}, '0);
        chk("reset_dut1", {stim1, busy1, done1, pass1, cap1, fi1}, '0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            if (!tbl[i].sel) mode0 = tbl[i].mode;
            sweep(tbl[i].sel, tbl[i].ev, dedge, sok, cok);
            chk($sformatf("done_edge[%0d]", i), dedge, tbl[i].dedge);
            chk($sformatf("stim_seq[%0d]", i), {31'd0, sok}, 1);
            chk($sformatf("accept_clear[%0d]", i), {31'd0, cok}, 1);
            chk($sformatf("pass[%0d]", i), ps(tbl[i].sel), tbl[i].pass);
            chk($sformatf("captured[%0d]", i), cp(tbl[i].sel), tbl[i].cap);
            chk($sformatf("fail_index[%0d]", i), fx(tbl[i].sel), tbl[i].fi);
            step();
            chk($sformatf("done_pulse[%0d]", i),
                {dn(tbl[i].sel), bsy(tbl[i].sel), ps(tbl[i].sel)},
                {2'b00, tbl[i].pass});
            step();
        end

        // Asynchronous reset while stim=2
        mode0     = 1'b0;
        expected0 = 4'b1011;
        start0    = 1'b1;
        step();
        start0 = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        chk("pre_reset_stim", stim0, 2'd2);
        nd = ndone0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {stim0, busy0, done0, pass0, cap0, fi0}, '0);
        step();
        step();
        step();
        #3;
        rst_n = 1'b1;
        step();
        step();
        chk("no_done_after_abort", ndone0 - nd, 0);
        sweep(1'b0, 4'b1011, dedge, sok, cok);
        chk("post_reset_done_edge", dedge, 8);
        chk("post_reset_pass", {pass0, cap0}, {1'b1, 4'b1011});
        step();
        step();

        // start re-pulsed in RUN and DONE; expected changed mid-sweep
        nd        = ndone0;
        expected0 = 4'b1011;
        start0    = 1'b1;
        step();
        start0 = 1'b0;
        for (int e = 1; e <= 3; e++) step();
        start0    = 1'b1;
        expected0 = 4'b1111;
        step();
        start0 = 1'b0;
        for (int e = 5; e <= 8; e++) step();
        chk("repulse_done_edge8", done0, 1'b1);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("repulse_idle_edge9", {busy0, done0}, 2'b00);
        for (int e = 0; e < 12; e++) step();
        chk("repulse_not_queued", busy0, 1'b0);
        chk("repulse_one_done", ndone0 - nd, 1);
        chk("repulse_result", {pass0, cap0, fi0}, {1'b1, 4'b1011, 2'd0});

        // start held high across two sweeps
        expected0 = 4'b1111;
        start0    = 1'b1;
        step();
        for (int e = 1; e <= 8; e++) step();
        chk("held_done1", {done0, cap0, fi0}, {1'b1, 4'b1011, 2'd2});
        step();
        chk("held_edge9_idle", {busy0, done0, cap0}, {2'b00, 4'b1011});
        step();
        chk("held_reaccept", {busy0, cap0, pass0}, {1'b1, 4'b0000, 1'b0});
        for (int e = 11; e <= 18; e++) step();
        start0 = 1'b0;
        chk("held_done2", {done0, pass0, cap0}, {2'b10, 4'b1011});
        step();
        chk("held_done2_drop", done0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
